// File: rtl/sync_sram_if.sv
// Local-bus port bundle for sync_sram: access request, clear request and registered responses.
interface sync_sram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int BE_W = DATA_W / 8;

  logic              cs;
  logic              wr;
  logic              rd;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              clr;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              err;

  modport master (
    output cs, wr, rd, be, addr, din, clr,
    input  dout, dout_valid, busy, err
  );

  modport slave (
    input  cs, wr, rd, be, addr, din, clr,
    output dout, dout_valid, busy, err
  );
endinterface

// File: rtl/sync_sram.sv
// Synchronous single-port SRAM with byte enables, registered read port and a
// clear engine that fills every word with INIT_VAL after reset or on clr.
module sync_sram #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_sram_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W:0]   ptr_r, ptr_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              in_range_s;
  logic              access_s;
  logic [DATA_W-1:0] dout_r, dout_nxt_s;
  logic              dout_valid_r, dout_valid_nxt_s;
  logic              err_r, err_nxt_s;
  logic              busy_r, busy_nxt_s;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   en
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (en[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign in_range_s = ({1'b0, bus.addr} < DEPTH_L);
  assign access_s   = bus.cs & (bus.wr | bus.rd);
  assign rd_word_s  = mem_r[bus.addr];

  // Next-state, clear pointer, array write port and response values.
  always_comb begin
    state_nxt_s      = state_r;
    ptr_nxt_s        = ptr_r;
    mem_we_s         = 1'b0;
    mem_waddr_s      = ptr_r[ADDR_W-1:0];
    mem_wdata_s      = INIT_VAL;
    dout_nxt_s       = dout_r;
    dout_valid_nxt_s = 1'b0;
    err_nxt_s        = 1'b0;
    case (state_r)
      ST_INIT: begin
        mem_we_s  = 1'b1;
        ptr_nxt_s = ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        if (ptr_r == LAST_L) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (bus.clr) begin
          state_nxt_s = ST_INIT;
          ptr_nxt_s   = {(ADDR_W+1){1'b0}};
        end else if (access_s && in_range_s) begin
          if (bus.wr) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = bus.addr;
            mem_wdata_s = merge_bytes(rd_word_s, bus.din, bus.be);
          end else begin
            mem_we_s = 1'b0;
          end
          // Read returns the pre-write word because rd_word_s is the current array value.
          if (bus.rd) begin
            dout_nxt_s       = rd_word_s;
            dout_valid_nxt_s = 1'b1;
          end else begin
            dout_valid_nxt_s = 1'b0;
          end
        end else if (access_s) begin
          err_nxt_s = 1'b1;
          if (bus.rd) begin
            dout_nxt_s       = {DATA_W{1'b0}};
            dout_valid_nxt_s = 1'b1;
          end else begin
            dout_valid_nxt_s = 1'b0;
          end
        end else begin
          dout_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        ptr_nxt_s   = {(ADDR_W+1){1'b0}};
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_INIT);
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT;
      ptr_r        <= {(ADDR_W+1){1'b0}};
      dout_r       <= {DATA_W{1'b0}};
      dout_valid_r <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      ptr_r        <= ptr_nxt_s;
      dout_r       <= dout_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      err_r        <= err_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  // Storage array; deliberately not reset, the clear engine defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.err        = err_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_sync_sram.sv
// Directed scoreboard bench for sync_sram (16-bit words, 12 entries, fill A5A5).
module tb_sync_sram;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 12;
  localparam logic [15:0] IV     = 16'hA5A5;

  typedef struct {
    logic        valid;
    logic        err;
    logic [15:0] dout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [15:0] model [DEPTH];

  sync_sram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sync_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_VAL(IV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock edge, then compare the response against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, e.valid});
      chk("err", {31'd0, bus.err}, {31'd0, e.err});
      if (e.valid) chk("dout", {16'd0, bus.dout}, {16'd0, e.dout});
    end else begin
      chk("idle_valid", {31'd0, bus.dout_valid}, 32'd0);
      chk("idle_err", {31'd0, bus.err}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic access(input logic w, input logic r, input logic [1:0] be,
                        input logic [3:0] a, input logic [15:0] d);
    exp_t e;
    logic [15:0] nw;
    bus.cs = 1'b1; bus.wr = w; bus.rd = r; bus.be = be;
    bus.addr = a; bus.din = d; bus.clr = 1'b0;
    if (int'(a) < DEPTH) begin
      if (r) begin
        e.valid = 1'b1; e.err = 1'b0; e.dout = model[a];
        sb.push_back(e);
      end
      if (w) begin
        nw = model[a];
        if (be[0]) nw[7:0]  = d[7:0];
        if (be[1]) nw[15:8] = d[15:8];
        model[a] = nw;
      end
    end else begin
      e.valid = r; e.err = 1'b1; e.dout = 16'h0000;
      sb.push_back(e);
    end
    step();
  endtask

  // Count edges until busy falls; bounded so a stuck engine cannot hang the run.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(tag, n, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = IV;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 2'b00, 4'(i), 16'h0000);
    bus.cs = 1'b0; bus.rd = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;
    bus.be = 2'b00; bus.addr = 4'h0; bus.din = 16'h0000;
    #22;
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_dout", {16'd0, bus.dout}, 32'd0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst_n = 1'b1;
    count_busy("clear_len_reset");
    read_all();

    access(1'b1, 1'b0, 2'b01, 4'd3, 16'h1234);
    access(1'b0, 1'b1, 2'b00, 4'd3, 16'h0000);
    access(1'b1, 1'b0, 2'b10, 4'd3, 16'hBEEF);
    access(1'b0, 1'b1, 2'b00, 4'd3, 16'h0000);
    access(1'b1, 1'b0, 2'b00, 4'd3, 16'hFFFF);
    access(1'b0, 1'b1, 2'b00, 4'd3, 16'h0000);
    chk("be_model", {16'd0, model[3]}, 32'h0000BE34);

    access(1'b1, 1'b1, 2'b11, 4'd5, 16'h0F0F);
    access(1'b0, 1'b1, 2'b00, 4'd5, 16'h0000);

    access(1'b1, 1'b0, 2'b11, 4'd13, 16'hDEAD);
    access(1'b0, 1'b1, 2'b00, 4'd15, 16'h0000);
    idle(2);
    access(1'b0, 1'b1, 2'b00, 4'd11, 16'h0000);
    idle(1);
    read_all();

    bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.be = 2'b11;
    bus.addr = 4'd2; bus.din = 16'h1111; bus.clr = 1'b1;
    step();
    bus.cs = 1'b0; bus.wr = 1'b0; bus.clr = 1'b0;
    chk("clr_busy", {31'd0, bus.busy}, 32'd1);
    count_busy("clear_len_clr");
    read_all();

    bus.cs = 1'b1; bus.clr = 1'b1;
    step();
    bus.cs = 1'b0; bus.clr = 1'b0;
    idle(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, bus.busy}, 32'd1);
    chk("async_dout", {16'd0, bus.dout}, 32'd0);
    chk("async_valid", {31'd0, bus.dout_valid}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    count_busy("clear_len_async");
    read_all();

    chk("queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
